// File: rtl/result_writer.sv
// rtl/result_writer.sv - buffers PE result pairs and writes them one word at a time to the output matrix memory
//
// Purpose: each valid input cycle carries two results that share an output
// row. Pairs are queued in a small FIFO and written to memory as two
// consecutive words, {row, col_1} then {row, col_2}, under a valid/ready
// handshake (o_mem_wen / i_mem_ready). A word counter pulses o_done once a
// whole matrix (OUT_WORDS words) has been written.
//
// Optional feature macro: RESULT_WRITER_RELU_EN
//   defined   : negative write data is clamped to 0 at the memory port
//   undefined : write data passes through unchanged
//
// Parameters:
//   FIFO_DEPTH  result-pair FIFO entries (power of two, >= 2)
//   OUT_WORDS   words per complete output matrix
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_valid                          result pair present this cycle
//   i_result_1, i_result_2           signed results
//   i_row_idx                        shared output row
//   i_col_idx_1, i_col_idx_2         output column of each result
//   i_mem_ready                      memory accepts a write this cycle
//   o_mem_wen, o_mem_addr, o_mem_wdata  write request, {row, col}, data
//   o_full                           FIFO holds FIFO_DEPTH entries
//   o_overflow                       sticky: a pair was dropped
//   o_done                           one-cycle pulse per completed matrix

module result_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_WORDS  = 800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [15:0] i_result_1,
  input  logic [15:0] i_result_2,
  input  logic [6:0]  i_row_idx,
  input  logic [2:0]  i_col_idx_1,
  input  logic [2:0]  i_col_idx_2,
  input  logic        i_mem_ready,
  output logic        o_mem_wen,
  output logic [9:0]  o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_full,
  output logic        o_overflow,
  output logic        o_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(OUT_WORDS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR1  = 2'd1;
  localparam logic [1:0] WR2  = 2'd2;

  typedef struct packed {
    logic [15:0] res_1;
    logic [15:0] res_2;
    logic [6:0]  row;
    logic [2:0]  col_1;
    logic [2:0]  col_2;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             settled_q, settled_d;
  logic             overflow_q, overflow_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             done_q, done_d;

  logic             push, pop, accept;
  logic [15:0]      wdata_raw;
  entry_t           head;

  assign head   = mem_q[rd_ptr_q];
  assign o_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop    = (state_q == WR2) && i_mem_ready;
  // A full FIFO still takes a pair when the head leaves on the same edge.
  assign push   = i_valid && (!o_full || pop);
  assign accept = o_mem_wen && i_mem_ready;

  // Write port: driven purely from the current state and FIFO head, so the
  // request stays stable for as long as the memory withholds i_mem_ready.
  always_comb begin
    o_mem_wen  = 1'b0;
    o_mem_addr = 10'd0;
    wdata_raw  = 16'd0;
    case (state_q)
      WR1: begin
        o_mem_wen  = 1'b1;
        o_mem_addr = {head.row, head.col_1};
        wdata_raw  = head.res_1;
      end
      WR2: begin
        o_mem_wen  = 1'b1;
        o_mem_addr = {head.row, head.col_2};
        wdata_raw  = head.res_2;
      end
      default: ;
    endcase
  end

`ifdef RESULT_WRITER_RELU_EN
  assign o_mem_wdata = wdata_raw[15] ? 16'h0000 : wdata_raw;
`else
  assign o_mem_wdata = wdata_raw;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wcnt_d     = wcnt_q;
    done_d     = 1'b0;
    // IDLE only leaves once the FIFO has been non-empty for a full cycle,
    // giving the head entry a settled cycle before the first write.
    settled_d  = (count_q != '0);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (i_valid && o_full && !pop) overflow_d = 1'b1;

    case (state_q)
      IDLE: if ((count_q != '0) && settled_q) state_d = WR1;
      WR1:  if (i_mem_ready) state_d = WR2;
      WR2:  if (i_mem_ready) state_d = (count_q > CNT_W'(1)) ? WR1 : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (wcnt_q == WC_W'(OUT_WORDS - 1)) begin
        wcnt_d = '0;
        done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      settled_q  <= 1'b0;
      overflow_q <= 1'b0;
      wcnt_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      settled_q  <= settled_d;
      overflow_q <= overflow_d;
      wcnt_q     <= wcnt_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{res_1: i_result_1, res_2: i_result_2, row: i_row_idx,
                           col_1: i_col_idx_1, col_2: i_col_idx_2};
    end
  end

  assign o_overflow = overflow_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - self-checking bench for result_writer

module tb_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_result_1, i_result_2;
  logic [6:0]  i_row_idx;
  logic [2:0]  i_col_idx_1, i_col_idx_2;
  logic        i_mem_ready;
  logic        o_mem_wen;
  logic [9:0]  o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_full, o_overflow, o_done;

  always #5 clk = ~clk;

  result_writer #(.FIFO_DEPTH(4), .OUT_WORDS(800)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid),
    .i_result_1(i_result_1), .i_result_2(i_result_2),
    .i_row_idx(i_row_idx), .i_col_idx_1(i_col_idx_1), .i_col_idx_2(i_col_idx_2),
    .i_mem_ready(i_mem_ready), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_full(o_full), .o_overflow(o_overflow), .o_done(o_done)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t exp_wr;
  int  checks = 0;
  int  failures = 0;
  int  mcount = 0;
  int  done_pulses = 0;
  bit  done_exp = 1'b0;

  function automatic logic [15:0] exp_data(input logic [15:0] d);
`ifdef RESULT_WRITER_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair for the next sampling edge; queues its two writes when
  // the bench expects the pair to be accepted.
  task automatic drive(input logic [6:0] row, input logic [2:0] c1, input logic [2:0] c2,
                       input logic [15:0] r1, input logic [15:0] r2, input bit accepted);
    i_valid     = 1'b1;
    i_row_idx   = row;
    i_col_idx_1 = c1;
    i_col_idx_2 = c2;
    i_result_1  = r1;
    i_result_2  = r2;
    if (accepted) begin
      sb.push_back('{addr: {row, c1}, data: exp_data(r1)});
      sb.push_back('{addr: {row, c2}, data: exp_data(r2)});
    end
  endtask

  task automatic wait_wen(input string tag);
    for (int i = 0; i < 20 && !o_mem_wen; i++) tick();
    chk(tag, o_mem_wen, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && !(sb.size() == 0 && !o_mem_wen); i++) tick();
    chk(tag, (sb.size() == 0 && !o_mem_wen), 1'b1);
  endtask

  // Write scoreboard and word-count / done model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("done_pulse", o_done, done_exp);
    if (o_done) done_pulses++;
    if (rst) begin
      mcount   = 0;
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (o_mem_wen && i_mem_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          exp_wr = sb.pop_front();
          chk("wr_addr", o_mem_addr, exp_wr.addr);
          chk("wr_data", o_mem_wdata, exp_wr.data);
        end
        if (mcount == 799) begin
          mcount   = 0;
          done_exp = 1'b1;
        end else begin
          mcount++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_mem_ready = 1'b1;
    i_result_1 = '0; i_result_2 = '0; i_row_idx = '0; i_col_idx_1 = '0; i_col_idx_2 = '0;
    tick(); tick();
    chk("rst_wen", o_mem_wen, 1'b0);
    chk("rst_addr", o_mem_addr, 10'd0);
    chk("rst_wdata", o_mem_wdata, 16'd0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_done", o_done, 1'b0);
    rst = 1'b0;
    tick();

    // Single pair, memory always ready: latency and write order.
    drive(7'd5, 3'd0, 3'd1, 16'h0012, 16'h0034, 1);
    tick();
    i_valid = 1'b0;
    chk("lat_edge0_wen", o_mem_wen, 1'b0);
    tick();
    chk("lat_edge1_wen", o_mem_wen, 1'b0);
    tick();
    chk("lat_edge2_wen", o_mem_wen, 1'b1);
    chk("single_addr1", o_mem_addr, 10'h028);
    chk("single_data1", o_mem_wdata, 16'h0012);
    tick();
    chk("single_wen2", o_mem_wen, 1'b1);
    chk("single_addr2", o_mem_addr, 10'h029);
    chk("single_data2", o_mem_wdata, 16'h0034);
    tick();
    chk("single_idle", o_mem_wen, 1'b0);
    chk("single_idle_addr", o_mem_addr, 10'd0);

    // Backpressure held in WR1.
    i_mem_ready = 1'b0;
    drive(7'd7, 3'd2, 3'd3, 16'h1111, 16'h2222, 1);
    tick();
    i_valid = 1'b0;
    wait_wen("bp_wait_wen");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_wen", o_mem_wen, 1'b1);
      chk("bp_hold_addr", o_mem_addr, {7'd7, 3'd2});
      chk("bp_hold_data", o_mem_wdata, 16'h1111);
      chk("bp_not_full", o_full, 1'b0);
    end
    i_mem_ready = 1'b1;
    wait_drain("bp_drain");

    // Overflow: five pairs into a stalled four-entry FIFO.
    i_mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        chk("ovf_full_after4", o_full, 1'b1);
        chk("ovf_clear_before5", o_overflow, 1'b0);
      end
      drive(7'(10 + k), 3'(k), 3'(k + 1), 16'(16'h0100 + k), 16'(16'h0200 + k), k < 4);
      tick();
    end
    i_valid = 1'b0;
    chk("ovf_set", o_overflow, 1'b1);
    tick(); tick(); tick();
    chk("ovf_sticky", o_overflow, 1'b1);
    i_mem_ready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky_drained", o_overflow, 1'b1);
    chk("ovf_empty_full", o_full, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_clears_ovf", o_overflow, 1'b0);

    // Full FIFO with a push on the same edge as the WR2 pop.
    i_mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(7'(20 + k), 3'(k), 3'(7 - k), 16'(16'h0A00 + k), 16'(16'h0B00 + k), 1);
      tick();
    end
    i_valid = 1'b0;
    tick(); tick(); tick();
    chk("fp_full", o_full, 1'b1);
    chk("fp_wr1_addr", o_mem_addr, 10'h0A0);
    i_mem_ready = 1'b1;
    tick();
    chk("fp_wr2_addr", o_mem_addr, 10'h0A7);
    chk("fp_still_full", o_full, 1'b1);
    drive(7'd30, 3'd1, 3'd2, 16'h4444, 16'h5555, 1);
    tick();
    i_valid = 1'b0;
    chk("fp_no_overflow", o_overflow, 1'b0);
    chk("fp_full_after_swap", o_full, 1'b1);
    wait_drain("fp_drain");
    chk("fp_no_overflow_end", o_overflow, 1'b0);

    // Full matrix: 400 pairs, o_done pulses once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_pulses = 0;
    for (int p = 0; p < 400; p++) begin
      drive(7'(p % 100), 3'(p % 8), 3'((p + 3) % 8), 16'(p), 16'(p * 3 + 1), 1);
      tick();
      i_valid = 1'b0;
      tick(); tick();
    end
    wait_drain("done_drain");
    tick(); tick();
    chk("done_once", done_pulses, 1);
    drive(7'd50, 3'd4, 3'd5, 16'h0777, 16'h0888, 1);
    tick();
    i_valid = 1'b0;
    wait_drain("restart_drain");
    tick(); tick();
    chk("restart_no_done", done_pulses, 1);

    // Negative and maximum positive data at the write port.
    i_mem_ready = 1'b0;
    drive(7'd99, 3'd6, 3'd7, 16'hFFF0, 16'h7FFF, 1);
    tick();
    i_valid = 1'b0;
    wait_wen("relu_wait");
`ifdef RESULT_WRITER_RELU_EN
    chk("relu_neg", o_mem_wdata, 16'h0000);
`else
    chk("relu_neg", o_mem_wdata, 16'hFFF0);
`endif
    i_mem_ready = 1'b1;
    tick();
    chk("relu_pos", o_mem_wdata, 16'h7FFF);
    wait_drain("relu_drain");

    // Reset drops an in-flight write and ignores i_valid.
    i_mem_ready = 1'b0;
    drive(7'd1, 3'd1, 3'd2, 16'h0AAA, 16'h0BBB, 0);
    tick();
    i_valid = 1'b0;
    wait_wen("inflight_wait");
    rst = 1'b1;
    drive(7'd2, 3'd3, 3'd4, 16'h0CCC, 16'h0DDD, 0);
    tick();
    i_valid = 1'b0;
    chk("inflight_wen_cleared", o_mem_wen, 1'b0);
    chk("inflight_fifo_empty", o_full, 1'b0);
    rst = 1'b0;
    i_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("inflight_discarded", o_mem_wen, 1'b0);
    end
    chk("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
